// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Imported by the interface, byte issuer and scheduler top.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    ID,
    FETCH,
    PAYLOAD,
    CKSUM
  } sched_state_e;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_START,
    ISS_WAIT_HI,
    ISS_WAIT_LO
  } iss_state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Single-step wrap of an index that can exceed n by less than n.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester, UART and status signals of the transmit scheduler.
// master = scheduler side, slave = requesters/UART/observer side.
interface uart_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 active;
  logic [IDW-1:0]       grant_id;
  logic                 pkt_done;
  logic                 pkt_trunc;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, active, grant_id, pkt_done, pkt_trunc
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, active, grant_id, pkt_done, pkt_trunc
  );

endinterface

// File: rtl/uart_tx_scheduler_issuer.sv
// Byte issuer: hands one byte to the UART via the start/busy handshake
// and pulses done_o once the transmitter has dropped busy again.
module uart_byte_issuer
  import uart_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_busy_i
);

  iss_state_e state_q, state_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ISS_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    done_o     = 1'b0;
    tx_start_o = 1'b0;
    case (state_q)
      ISS_IDLE: begin
        if (issue_i && !tx_busy_i) begin
          data_d  = byte_i;
          state_d = ISS_START;
        end
      end
      ISS_START: begin
        tx_start_o = 1'b1;
        state_d    = ISS_WAIT_HI;
      end
      ISS_WAIT_HI: begin
        if (tx_busy_i) state_d = ISS_WAIT_HI == ISS_WAIT_HI ? ISS_WAIT_LO : ISS_WAIT_HI;
      end
      ISS_WAIT_LO: begin
        if (!tx_busy_i) begin
          done_o  = 1'b1;
          state_d = ISS_IDLE;
        end
      end
      default: state_d = ISS_IDLE;
    endcase
  end

  // Data is held from the start strobe until the byte completes.
  assign tx_data_o = data_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin packet scheduler sharing one UART transmitter between NUM_REQ sources.
// Frame: SOF, source ID, payload, plus trailing checksum when UART_SCHED_CHECKSUM_EN is defined.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_LEN  = 64,
  parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned LENW = $clog2(MAX_LEN + 1);

  sched_state_e     state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             active_q, active_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             trunc_q, trunc_d;
  logic             done_q, done_d;
  logic             trunc_pls_q, trunc_pls_d;
`ifdef UART_SCHED_CHECKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic             found;
  logic [IDW-1:0]   pick;
  logic             at_max;
  logic [7:0]       pay_byte;
  logic             iss_req;
  logic [7:0]       iss_byte;
  logic             iss_done;
  logic [NUM_REQ-1:0] ready;
  logic [IDW-1:0]   ptr_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      active_q    <= 1'b0;
      len_q       <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      trunc_q     <= 1'b0;
      done_q      <= 1'b0;
      trunc_pls_q <= 1'b0;
`ifdef UART_SCHED_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      active_q    <= active_d;
      len_q       <= len_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      trunc_q     <= trunc_d;
      done_q      <= done_d;
      trunc_pls_q <= trunc_pls_d;
`ifdef UART_SCHED_CHECKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'(rr_wrap(32'(ptr_q) + i, NUM_REQ));
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pay_byte = bus.req_data[{grant_q, 3'b000} +: 8];
  assign at_max   = (len_q == LENW'(MAX_LEN - 1));
  assign ptr_next = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    iss_req  = 1'b0;
    iss_byte = '0;
    case (state_q)
      SOF: begin
        iss_req  = 1'b1;
        iss_byte = SOF_BYTE;
      end
      ID: begin
        iss_req  = 1'b1;
        iss_byte = 8'(grant_q);
      end
      PAYLOAD: begin
        iss_req  = 1'b1;
        iss_byte = byte_q;
      end
`ifdef UART_SCHED_CHECKSUM_EN
      CKSUM: begin
        iss_req  = 1'b1;
        iss_byte = cksum_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    active_d    = active_q;
    len_d       = len_q;
    byte_d      = byte_q;
    last_d      = last_q;
    trunc_d     = trunc_q;
    done_d      = 1'b0;
    trunc_pls_d = 1'b0;
    ready       = '0;
`ifdef UART_SCHED_CHECKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          active_d = 1'b1;
          len_d    = '0;
`ifdef UART_SCHED_CHECKSUM_EN
          cksum_d  = '0;
`endif
          state_d  = SOF;
        end
      end
      SOF: begin
        if (iss_done) state_d = ID;
      end
      ID: begin
        if (iss_done) begin
`ifdef UART_SCHED_CHECKSUM_EN
          cksum_d = cksum_q + 8'(grant_q);
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.req_valid[grant_q]) begin
          ready[grant_q] = 1'b1;
          byte_d  = pay_byte;
          last_d  = bus.req_last[grant_q] || at_max;
          trunc_d = at_max && !bus.req_last[grant_q];
          len_d   = len_q + LENW'(1);
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (iss_done) begin
`ifdef UART_SCHED_CHECKSUM_EN
          cksum_d = cksum_q + byte_q;
          state_d = last_q ? CKSUM : FETCH;
`else
          if (last_q) begin
            done_d      = 1'b1;
            trunc_pls_d = trunc_q;
            ptr_d       = ptr_next;
            active_d    = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = FETCH;
          end
`endif
        end
      end
`ifdef UART_SCHED_CHECKSUM_EN
      CKSUM: begin
        if (iss_done) begin
          done_d      = 1'b1;
          trunc_pls_d = trunc_q;
          ptr_d       = ptr_next;
          active_d    = 1'b0;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  uart_byte_issuer u_issuer (
    .clk        (clk),
    .reset      (reset),
    .issue_i    (iss_req),
    .byte_i     (iss_byte),
    .done_o     (iss_done),
    .tx_data_o  (bus.tx_data),
    .tx_start_o (bus.tx_start),
    .tx_busy_i  (bus.tx_busy)
  );

  assign bus.req_ready = ready;
  assign bus.active    = active_q;
  assign bus.grant_id  = grant_q;
  assign bus.pkt_done  = done_q;
  assign bus.pkt_trunc = trunc_pls_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: randomized requester traffic against a
// packet-level reference model of round-robin framing, truncation and checksums.
module tb_uart_tx_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned MAXL = 4;
  localparam logic [7:0]  SOFB = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ  (NREQ),
    .MAX_LEN  (MAXL),
    .SOF_BYTE (SOFB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic        model_busy, force_busy, start_pend;
  int unsigned busy_len, busy_cnt;
  assign bus.tx_busy = model_busy | force_busy;

  logic [8:0]  rq[NREQ][$];
  logic [8:0]  mq[NREQ][$];
  logic [NREQ-1:0] stall, hs;
  logic [7:0]  got_bytes[$], exp_bytes[$];
  bit          got_trunc[$], exp_trunc[$];
  logic [7:0]  win_data;
  int          starts, bad_start, unstable, ready_err, trunc_orphan;
  int          mptr;
  int          checks, failures;

  function automatic void drive();
    logic [NREQ-1:0]   v, l;
    logic [NREQ*8-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0 && !stall[i]) begin
        v[i] = 1'b1;
        d[i*8 +: 8] = rq[i][0][7:0];
        l[i] = rq[i][0][8];
      end else begin
        d[i*8 +: 8] = 8'($urandom);
        l[i] = 1'($urandom);
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endfunction

  task automatic tick();
    logic [NREQ-1:0] oh;
    @(negedge clk);
    if (bus.tx_start) begin
      starts++;
      if (bus.tx_busy) bad_start++;
      got_bytes.push_back(bus.tx_data);
      win_data   = bus.tx_data;
      start_pend = 1'b1;
    end else if (model_busy && bus.tx_data !== win_data) begin
      unstable++;
    end
    if (bus.req_ready != '0) begin
      oh = '0;
      oh[bus.grant_id] = 1'b1;
      if (!bus.active || bus.req_ready != oh) ready_err++;
    end
    hs = bus.req_ready & bus.req_valid;
    if (bus.pkt_done) got_trunc.push_back(bus.pkt_trunc);
    else if (bus.pkt_trunc) trunc_orphan++;
    @(posedge clk);
    #1;
    if (start_pend) begin
      model_busy = 1'b1;
      busy_cnt   = busy_len;
      start_pend = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
    for (int i = 0; i < NREQ; i++)
      if (hs[i]) void'(rq[i].pop_front());
    drive();
  endtask

  function automatic void push_byte(int r, logic [7:0] b, logic last);
    rq[r].push_back({last, b});
    mq[r].push_back({last, b});
  endfunction

  function automatic void load_pkt(int r, int n);
    for (int k = 0; k < n; k++) push_byte(r, 8'($urandom), k == n - 1);
  endfunction

  // Packet-level reference: whole frames in grant order from the pending byte lists.
  function automatic void build_expected();
    int found, n;
    bit fin, tr;
    logic [8:0] e;
    logic [7:0] sum;
    forever begin
      found = -1;
      for (int k = 0; k < NREQ; k++)
        if (found < 0 && mq[(mptr + k) % NREQ].size() > 0) found = (mptr + k) % NREQ;
      if (found < 0) break;
      exp_bytes.push_back(SOFB);
      exp_bytes.push_back(8'(found));
      sum = 8'(found);
      n = 0; fin = 0; tr = 0;
      while (!fin && mq[found].size() > 0) begin
        e = mq[found].pop_front();
        exp_bytes.push_back(e[7:0]);
        sum = sum + e[7:0];
        n++;
        if (e[8]) fin = 1;
        else if (n == MAXL) begin fin = 1; tr = 1; end
      end
`ifdef UART_SCHED_CHECKSUM_EN
      exp_bytes.push_back(sum);
`endif
      exp_trunc.push_back(tr);
      mptr = (found + 1) % NREQ;
    end
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run(input int budget, output bit timed_out);
    int cyc;
    cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (all_empty() && !bus.active && !model_busy && got_trunc.size() >= exp_trunc.size()) break;
    end
    timed_out = (cyc >= budget);
  endtask

  task automatic stream_diff(output int idx, output logic [7:0] g, output logic [7:0] e);
    int n;
    idx = -1; g = 'x; e = 'x;
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int k = 0; k < n; k++)
      if (idx < 0 && got_bytes[k] !== exp_bytes[k]) begin idx = k; g = got_bytes[k]; e = exp_bytes[k]; end
    if (idx < 0 && got_bytes.size() != exp_bytes.size()) idx = n;
  endtask

  function automatic logic [31:0] trunc_bits(bit sel_got);
    logic [31:0] r;
    r = '0;
    if (sel_got) foreach (got_trunc[k]) r[k] = got_trunc[k];
    else         foreach (exp_trunc[k]) r[k] = exp_trunc[k];
    return r;
  endfunction

  function automatic void clear_results();
    got_bytes.delete(); exp_bytes.delete();
    got_trunc.delete(); exp_trunc.delete();
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive();
    repeat (3) tick();
    checks++; if (bus.req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (bus.tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", bus.tx_start); end
    checks++; if (bus.active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", bus.active); end
    checks++; if (bus.grant_id !== '0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.pkt_done !== 1'b0 || bus.pkt_trunc !== 1'b0) begin failures++; $display("FAIL reset_pkt_flags got=%b%b exp=00", bus.pkt_done, bus.pkt_trunc); end
    reset = 1'b0;
    mptr = 0;
    tick();
  endtask

  task automatic test_basic();
    bit to; int d; logic [7:0] g, e;
    clear_results();
    busy_len = 20;
    push_byte(0, 8'h11, 1'b0);
    push_byte(0, 8'h22, 1'b1);
    build_expected();
    run(2000, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
    stream_diff(d, g, e);
    checks++; if (d >= 0) begin failures++; $display("FAIL basic_stream idx=%0d got=%h exp=%h got_len=%0d exp_len=%0d", d, g, e, got_bytes.size(), exp_bytes.size()); end
    checks++; if (got_trunc.size() != 1 || got_trunc[0] !== 1'b0) begin failures++; $display("FAIL basic_done got_pkts=%0d exp_pkts=1 trunc_exp=0", got_trunc.size()); end
  endtask

  task automatic test_round_robin();
    bit to; int d; logic [7:0] g, e;
    for (int round = 0; round < 3; round++) begin
      clear_results();
      busy_len = $urandom_range(1, 6);
      if (round != 0) load_pkt(1, $urandom_range(1, 3));
      if (round != 1) begin
        load_pkt(3, $urandom_range(1, 3));
        if (round == 0) load_pkt(1, $urandom_range(1, 3));
      end
      build_expected();
      run(4000, to);
      checks++; if (to) begin failures++; $display("FAIL rr_timeout round=%0d got=timeout exp=done", round); end
      stream_diff(d, g, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL rr_stream round=%0d idx=%0d got=%h exp=%h", round, d, g, e); end
    end
    checks++; if (got_bytes.size() < 2 || got_bytes[1] !== 8'd3) begin failures++; $display("FAIL rr_ptr2_first_id got=%h exp=03", (got_bytes.size() > 1) ? got_bytes[1] : 8'hxx); end
  endtask

  task automatic test_maxlen();
    bit to; int d; logic [7:0] g, e;
    clear_results();
    busy_len = 3;
    for (int k = 0; k < 6; k++) push_byte(2, 8'($urandom), k == 5);
    build_expected();
    run(4000, to);
    checks++; if (to) begin failures++; $display("FAIL maxlen_timeout got=timeout exp=done"); end
    stream_diff(d, g, e);
    checks++; if (d >= 0) begin failures++; $display("FAIL maxlen_stream idx=%0d got=%h exp=%h", d, g, e); end
    checks++; if (got_trunc.size() != 2 || trunc_bits(1) !== 32'b01) begin failures++; $display("FAIL maxlen_trunc got=%b pkts=%0d exp=01 pkts=2", trunc_bits(1), got_trunc.size()); end
  endtask

  task automatic test_busy_hold();
    bit to; int d, s0; logic [7:0] g, e;
    clear_results();
    busy_len = 4;
    force_busy = 1'b1;
    load_pkt(1, 3);
    build_expected();
    s0 = starts;
    repeat (60) tick();
    checks++; if (starts != s0) begin failures++; $display("FAIL busy_no_start got=%0d exp=0", starts - s0); end
    checks++; if (bus.active !== 1'b1 || bus.grant_id !== 2'd1) begin failures++; $display("FAIL busy_grant got=%b/%0d exp=1/1", bus.active, bus.grant_id); end
    force_busy = 1'b0;
    run(2000, to);
    checks++; if (to) begin failures++; $display("FAIL busy_timeout got=timeout exp=done"); end
    stream_diff(d, g, e);
    checks++; if (d >= 0) begin failures++; $display("FAIL busy_stream idx=%0d got=%h exp=%h", d, g, e); end
    checks++; if (starts - s0 != exp_bytes.size()) begin failures++; $display("FAIL busy_start_count got=%0d exp=%0d", starts - s0, exp_bytes.size()); end
  endtask

  task automatic test_stall();
    bit to; int d, s0, cyc; logic [7:0] g, e;
    clear_results();
    busy_len = 4;
    load_pkt(0, 3);
    build_expected();
    cyc = 0;
    while (rq[0].size() != 2 && cyc < 500) begin tick(); cyc++; end
    checks++; if (cyc >= 500) begin failures++; $display("FAIL stall_first_accept got=timeout exp=accept"); end
    stall[0] = 1'b1;
    drive();
    repeat (40) tick();
    s0 = starts;
    repeat (100) tick();
    checks++; if (starts != s0) begin failures++; $display("FAIL stall_no_start got=%0d exp=0", starts - s0); end
    checks++; if (bus.active !== 1'b1 || bus.grant_id !== 2'd0) begin failures++; $display("FAIL stall_grant got=%b/%0d exp=1/0", bus.active, bus.grant_id); end
    stall[0] = 1'b0;
    drive();
    run(2000, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
    stream_diff(d, g, e);
    checks++; if (d >= 0) begin failures++; $display("FAIL stall_stream idx=%0d got=%h exp=%h", d, g, e); end
  endtask

  task automatic test_random();
    bit to, any; int d; logic [7:0] g, e;
    for (int round = 0; round < 6; round++) begin
      clear_results();
      busy_len = $urandom_range(1, 8);
      any = 0;
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1;
          for (int p = 0; p < $urandom_range(1, 2); p++) load_pkt(r, $urandom_range(1, 6));
        end
      end
      if (!any) load_pkt(0, $urandom_range(1, 6));
      build_expected();
      run(8000, to);
      checks++; if (to) begin failures++; $display("FAIL rand_timeout round=%0d got=timeout exp=done", round); end
      stream_diff(d, g, e);
      checks++; if (d >= 0) begin failures++; $display("FAIL rand_stream round=%0d idx=%0d got=%h exp=%h", round, d, g, e); end
      checks++; if (trunc_bits(1) !== trunc_bits(0) || got_trunc.size() != exp_trunc.size()) begin failures++; $display("FAIL rand_trunc round=%0d got=%b exp=%b", round, trunc_bits(1), trunc_bits(0)); end
    end
  endtask

  task automatic test_reset_midpacket();
    bit to; int d, s0, cyc; logic [7:0] g, e;
    clear_results();
    busy_len = 10;
    load_pkt(1, 4);
    s0 = starts;
    cyc = 0;
    while (starts < s0 + 3 && cyc < 500) begin tick(); cyc++; end
    checks++; if (cyc >= 500) begin failures++; $display("FAIL rstmid_reach_payload got=timeout exp=payload"); end
    #2;
    reset = 1'b1;
    model_busy = 1'b0; busy_cnt = 0; start_pend = 1'b0;
    #1;
    checks++; if (bus.active !== 1'b0 || bus.grant_id !== '0) begin failures++; $display("FAIL rstmid_status got=%b/%0d exp=0/0", bus.active, bus.grant_id); end
    checks++; if (bus.tx_data !== 8'h00 || bus.tx_start !== 1'b0) begin failures++; $display("FAIL rstmid_tx got=%h/%b exp=00/0", bus.tx_data, bus.tx_start); end
    checks++; if (bus.req_ready !== '0 || bus.pkt_done !== 1'b0 || bus.pkt_trunc !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b/%b/%b exp=0/0/0", bus.req_ready, bus.pkt_done, bus.pkt_trunc); end
    for (int i = 0; i < NREQ; i++) begin rq[i].delete(); mq[i].delete(); end
    drive();
    repeat (2) tick();
    reset = 1'b0;
    mptr = 0;
    clear_results();
    load_pkt(3, 2);
    build_expected();
    run(2000, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_timeout got=timeout exp=done"); end
    stream_diff(d, g, e);
    checks++; if (d >= 0) begin failures++; $display("FAIL rstmid_stream idx=%0d got=%h exp=%h", d, g, e); end
  endtask

  task automatic test_invariants();
    checks++; if (bad_start != 0) begin failures++; $display("FAIL inv_start_while_busy got=%0d exp=0", bad_start); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL inv_tx_data_stable got=%0d exp=0", unstable); end
    checks++; if (ready_err != 0) begin failures++; $display("FAIL inv_ready_onehot_granted got=%0d exp=0", ready_err); end
    checks++; if (trunc_orphan != 0) begin failures++; $display("FAIL inv_trunc_without_done got=%0d exp=0", trunc_orphan); end
  endtask

  initial begin
    checks = 0; failures = 0;
    starts = 0; bad_start = 0; unstable = 0; ready_err = 0; trunc_orphan = 0;
    model_busy = 1'b0; force_busy = 1'b0; start_pend = 1'b0;
    busy_len = 4; busy_cnt = 0; win_data = '0;
    stall = '0; hs = '0; mptr = 0;
    reset = 1'b1;
    drive();
    test_reset();
    test_round_robin();
    test_basic();
    test_maxlen();
    test_busy_hold();
    test_stall();
    test_random();
    test_reset_midpacket();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
